// File: rtl/rom_pattern_reader.sv
// Read-side sequencer for the BIST pattern ROM: walks addresses 0..DEPTH-1, captures each
// registered ROM word and pushes it into the FIFO write port, stalling while the FIFO is full.
module rom_pattern_reader #(
  parameter int unsigned SIZE  = 10,
  parameter int unsigned DEPTH = 10
) (
  input  logic            R_CLK,
  input  logic            RST,
  input  logic            START,
  output logic            ROM_EN,
  output logic [3:0]      ROM_ADDR,
  input  logic [SIZE-1:0] ROM_DATA,
  input  logic            FIFO_FULL,
  output logic            WR_EN,
  output logic [SIZE-1:0] WR_DATA,
  output logic [3:0]      WR_COUNT,
  output logic            BUSY,
  output logic            DONE
);

  localparam logic [3:0] LastAddr = 4'(DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StPush,
    StFinish
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      addr_q, addr_d;
  logic [3:0]      count_q, count_d;
  logic [SIZE-1:0] hold_q, hold_d;

  // State register
  always_ff @(posedge R_CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a full FIFO parks the machine in StPush with nothing advanced
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (START) state_d = StFetch;
      StFetch:   state_d = StCapture;
      StCapture: state_d = StPush;
      StPush: begin
        if (!FIFO_FULL) begin
          state_d = (addr_q == LastAddr) ? StFinish : StFetch;
        end
      end
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    ROM_EN = 1'b0;
    WR_EN  = 1'b0;
    BUSY   = 1'b1;
    DONE   = 1'b0;
    unique case (state_q)
      StIdle:    BUSY = 1'b0;
      StFetch:   ROM_EN = 1'b1;
      StCapture: ;
      StPush:    WR_EN = !FIFO_FULL;
      StFinish:  DONE = 1'b1;
      default:   BUSY = 1'b0;
    endcase
  end

  // Datapath next-state: address, pushed-word count and the captured ROM word
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          addr_d  = 4'd0;
          count_d = 4'd0;
        end
      end
      StCapture: hold_d = ROM_DATA;
      StPush: begin
        if (!FIFO_FULL) begin
          count_d = count_q + 4'd1;
          // The address stops at the last word; there is no wrap within a run.
          if (addr_q != LastAddr) addr_d = addr_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge R_CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= 4'd0;
      count_q <= 4'd0;
      hold_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  assign ROM_ADDR = addr_q;
  assign WR_COUNT = count_q;
  assign WR_DATA  = hold_q;

endmodule

// File: tb/tb_rom_pattern_reader.sv
// Randomised self-checking bench for rom_pattern_reader; expected write/fetch/done timing is
// derived from a per-word schedule (fetch, capture, then first non-full cycle writes).
module tb_rom_pattern_reader;

  localparam int SIZE = 10;
  localparam int DEPTH = 10;
  localparam int MAXC = 256;

  logic            R_CLK = 1'b0;
  logic            RST = 1'b0;
  logic            START = 1'b0;
  logic            FIFO_FULL = 1'b0;
  logic [SIZE-1:0] ROM_DATA = '0;
  logic            ROM_EN;
  logic [3:0]      ROM_ADDR;
  logic            WR_EN;
  logic [SIZE-1:0] WR_DATA;
  logic [3:0]      WR_COUNT;
  logic            BUSY;
  logic            DONE;

  logic [SIZE-1:0] mem [16];

  int n_cmp = 0;
  int n_err = 0;

  int full_pat  [MAXC];
  int exp_fetch [MAXC];
  int exp_wr    [MAXC];
  int exp_cnt   [MAXC];
  int exp_done  [MAXC];
  int exp_busy  [MAXC];

  rom_pattern_reader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .R_CLK    (R_CLK),
    .RST      (RST),
    .START    (START),
    .ROM_EN   (ROM_EN),
    .ROM_ADDR (ROM_ADDR),
    .ROM_DATA (ROM_DATA),
    .FIFO_FULL(FIFO_FULL),
    .WR_EN    (WR_EN),
    .WR_DATA  (WR_DATA),
    .WR_COUNT (WR_COUNT),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 R_CLK = ~R_CLK;

  // Pattern ROM with one-cycle registered read
  always @(posedge R_CLK) if (ROM_EN) ROM_DATA <= mem[ROM_ADDR];

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      full_pat[i]  = 0;
      exp_fetch[i] = -1;
      exp_wr[i]    = -1;
      exp_cnt[i]   = 0;
      exp_done[i]  = 0;
      exp_busy[i]  = 0;
    end
  endtask

  // Schedule one run whose START is sampled at edge e0; cycle c lies between edges c-1 and c.
  task automatic build_run(input int e0, output int done);
    int t;
    int cnt;
    t = e0;
    for (int k = 0; k < DEPTH; k++) begin
      t = t + 1;
      exp_fetch[t] = k;
      t = t + 2;
      while (t < MAXC - 4 && full_pat[t] != 0) t++;
      exp_wr[t] = k;
    end
    done = t + 1;
    exp_done[done] = 1;
    for (int c = e0 + 1; c <= done; c++) exp_busy[c] = 1;
    cnt = 0;
    for (int c = e0 + 1; c < MAXC; c++) begin
      exp_cnt[c] = cnt;
      if (exp_wr[c] >= 0 && c <= done) cnt++;
    end
  endtask

  // Pulse START across edge 0, then step ncyc cycles comparing every output against the model.
  task automatic run_cycles(input string name, input int ncyc, input int pulse_cyc,
                            input int hold_until, output int wr_seen, output int done_seen);
    wr_seen = 0;
    done_seen = 0;
    START = 1'b1;
    FIFO_FULL = 1'b0;
    @(posedge R_CLK);
    #1;
    for (int c = 1; c <= ncyc; c++) begin
      START = (c == pulse_cyc) || (c <= hold_until);
      FIFO_FULL = (full_pat[c] != 0);
      @(negedge R_CLK);
      n_cmp++;
      if (ROM_EN !== (exp_fetch[c] >= 0)) begin
        n_err++;
        $display("FAIL %s rom_en cyc %0d: got %b want %b", name, c, ROM_EN, exp_fetch[c] >= 0);
      end
      if (exp_fetch[c] >= 0) begin
        n_cmp++;
        if (ROM_ADDR !== 4'(exp_fetch[c])) begin
          n_err++;
          $display("FAIL %s rom_addr cyc %0d: got %0d want %0d", name, c, ROM_ADDR,
                   exp_fetch[c]);
        end
      end
      n_cmp++;
      if (WR_EN !== (exp_wr[c] >= 0)) begin
        n_err++;
        $display("FAIL %s wr_en cyc %0d: got %b want %b", name, c, WR_EN, exp_wr[c] >= 0);
      end
      if (WR_EN === 1'b1) wr_seen++;
      if (exp_wr[c] >= 0) begin
        n_cmp++;
        if (WR_DATA !== mem[4'(exp_wr[c])]) begin
          n_err++;
          $display("FAIL %s wr_data cyc %0d: got %0h want %0h", name, c, WR_DATA,
                   mem[4'(exp_wr[c])]);
        end
      end
      n_cmp++;
      if (DONE !== (exp_done[c] != 0)) begin
        n_err++;
        $display("FAIL %s done cyc %0d: got %b want %b", name, c, DONE, exp_done[c] != 0);
      end
      if (DONE === 1'b1) done_seen++;
      n_cmp++;
      if (BUSY !== (exp_busy[c] != 0)) begin
        n_err++;
        $display("FAIL %s busy cyc %0d: got %b want %b", name, c, BUSY, exp_busy[c] != 0);
      end
      n_cmp++;
      if (WR_COUNT !== 4'(exp_cnt[c])) begin
        n_err++;
        $display("FAIL %s wr_count cyc %0d: got %0d want %0d", name, c, WR_COUNT, exp_cnt[c]);
      end
      @(posedge R_CLK);
      #1;
    end
    START = 1'b0;
    FIFO_FULL = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) mem[i] = SIZE'(i * 3 + 1);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({ROM_EN, ROM_ADDR, WR_EN, WR_DATA, WR_COUNT, BUSY, DONE} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got en=%b addr=%0d wr=%b data=%0h cnt=%0d busy=%b done=%b want all 0",
                 ROM_EN, ROM_ADDR, WR_EN, WR_DATA, WR_COUNT, BUSY, DONE);
      end
      @(posedge R_CLK);
      #1;
    end
    RST = 1'b0;
    @(posedge R_CLK);
    #1;
  endtask

  task automatic check_totals(input string name, input int wr_seen, input int want_wr,
                              input int done_seen, input int want_done);
    n_cmp++;
    if (wr_seen != want_wr) begin
      n_err++;
      $display("FAIL %s write_total: got %0d want %0d", name, wr_seen, want_wr);
    end
    n_cmp++;
    if (done_seen != want_done) begin
      n_err++;
      $display("FAIL %s done_total: got %0d want %0d", name, done_seen, want_done);
    end
    n_cmp++;
    if (WR_COUNT !== 4'(DEPTH)) begin
      n_err++;
      $display("FAIL %s final_count: got %0d want %0d", name, WR_COUNT, DEPTH);
    end
  endtask

  task automatic test_basic();
    int done, wr, dn;
    clear_model();
    load_ramp();
    build_run(0, done);
    run_cycles("basic", done + 3, -1, 0, wr, dn);
    check_totals("basic", wr, DEPTH, dn, 1);
  endtask

  task automatic test_full_stall();
    int done, wr, dn;
    clear_model();
    load_ramp();
    for (int c = 3; c < 8; c++) full_pat[c] = 1;
    build_run(0, done);
    run_cycles("full_stall", done + 3, -1, 0, wr, dn);
    check_totals("full_stall", wr, DEPTH, dn, 1);
  endtask

  task automatic test_full_alternate();
    int done, wr, dn;
    clear_model();
    load_ramp();
    for (int c = 1; c < MAXC; c++) full_pat[c] = c % 2;
    build_run(0, done);
    run_cycles("full_alt", done + 3, -1, 0, wr, dn);
    check_totals("full_alt", wr, DEPTH, dn, 1);
  endtask

  task automatic test_start_ignored();
    int done, wr, dn;
    clear_model();
    load_ramp();
    build_run(0, done);
    run_cycles("start_busy", done + 3, 10, 0, wr, dn);
    check_totals("start_busy", wr, DEPTH, dn, 1);
  endtask

  task automatic test_reset_mid_run();
    int done, wr, dn;
    clear_model();
    load_ramp();
    build_run(0, done);
    run_cycles("pre_reset", 13, -1, 0, wr, dn);
    RST = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({ROM_EN, ROM_ADDR, WR_EN, WR_DATA, WR_COUNT, BUSY, DONE} !== '0) begin
        n_err++;
        $display("FAIL mid_reset_outputs step %0d: got en=%b addr=%0d wr=%b cnt=%0d busy=%b done=%b want all 0",
                 i, ROM_EN, ROM_ADDR, WR_EN, WR_COUNT, BUSY, DONE);
      end
      @(negedge R_CLK);
    end
    @(posedge R_CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge R_CLK);
      n_cmp++;
      if ({WR_EN, DONE, BUSY} !== 3'b000) begin
        n_err++;
        $display("FAIL post_reset_idle step %0d: got wr=%b done=%b busy=%b want 000",
                 i, WR_EN, DONE, BUSY);
      end
    end
    @(posedge R_CLK);
    #1;
    clear_model();
    build_run(0, done);
    run_cycles("after_reset", done + 3, -1, 0, wr, dn);
    check_totals("after_reset", wr, DEPTH, dn, 1);
  endtask

  task automatic test_back_to_back();
    int d1, d2, wr, dn;
    clear_model();
    load_ramp();
    build_run(0, d1);
    build_run(d1 + 1, d2);
    run_cycles("back_to_back", d2 + 4, -1, d2, wr, dn);
    check_totals("back_to_back", wr, 2 * DEPTH, dn, 2);
  endtask

  task automatic test_random();
    int done, wr, dn;
    for (int it = 0; it < 4; it++) begin
      clear_model();
      for (int i = 0; i < 16; i++) mem[i] = SIZE'($urandom);
      for (int c = 1; c < MAXC - 8; c++) full_pat[c] = ($urandom_range(0, 9) < 4) ? 1 : 0;
      build_run(0, done);
      run_cycles("random", done + 2, -1, 0, wr, dn);
      check_totals("random", wr, DEPTH, dn, 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_stall();
    test_full_alternate();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
